// File: rtl/mem_arbiter.sv
// Single-ported RAM arbiter: serialises instruction fetches and data loads/stores,
// data side first, with a sticky error state on RAM fault or access timeout.
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        ihit,
    output logic        dhit,
    output logic [31:0] iload,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        error
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        RAM_FREE   = 2'd0,
        RAM_BUSY   = 2'd1,
        RAM_ACCESS = 2'd2,
        RAM_ERROR  = 2'd3
    } ram_state_t;

    typedef enum logic [2:0] {
        IDLE,
        IACC,
        DACC,
        RESP,
        ERR
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic [31:0]   addr_q;
    logic [31:0]   data_q;
    logic          wr_q;
    logic          is_d_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (dWEN || dREN) state_nxt = DACC;
                else if (iREN)    state_nxt = IACC;
            end
            IACC, DACC: begin
                if (ramstate == RAM_ACCESS)
                    state_nxt = RESP;
                else if (ramstate == RAM_ERROR || cnt == CNT_LAST)
                    state_nxt = ERR;
            end
            RESP:    state_nxt = IDLE;
            ERR:     state_nxt = ERR;
            default: state_nxt = IDLE;
        endcase
    end

    // Request latch, load capture and timeout counter; the counter is cleared
    // in IDLE, which is the only way into an access state.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt    <= '0;
            addr_q <= '0;
            data_q <= '0;
            wr_q   <= 1'b0;
            is_d_q <= 1'b0;
            iload  <= '0;
            dload  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (dWEN || dREN) begin
                        addr_q <= daddr;
                        data_q <= dstore;
                        wr_q   <= dWEN;
                        is_d_q <= 1'b1;
                    end else if (iREN) begin
                        addr_q <= iaddr;
                        wr_q   <= 1'b0;
                        is_d_q <= 1'b0;
                    end
                end
                IACC, DACC: begin
                    if (ramstate == RAM_ACCESS) begin
                        if (state == IACC) iload <= ramload;
                        else if (!wr_q)    dload <= ramload;
                    end else if (cnt != CNT_LAST) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ramREN   = (state == IACC) || (state == DACC && !wr_q);
    assign ramWEN   = (state == DACC) && wr_q;
    assign ihit     = (state == RESP) && !is_d_q;
    assign dhit     = (state == RESP) && is_d_q;
    assign error    = (state == ERR);
    assign ramaddr  = addr_q;
    assign ramstore = data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a per-cycle vector table for fetch/store/priority,
// then hand-written sequences for async reset, timeout and RAM error.
module tb_mem_arbiter;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore;
    logic        ihit, dhit, ramREN, ramWEN, error;
    logic [31:0] iload, dload, ramaddr, ramstore, ramload;
    logic [1:0]  ramstate;

    int n_cmp = 0;
    int n_bad = 0;

    mem_arbiter #(.TIMEOUT(4)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .ihit(ihit), .dhit(dhit), .iload(iload), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .error(error)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        iren;
        logic [31:0] iaddr;
        logic        dren;
        logic        dwen;
        logic [31:0] daddr;
        logic [31:0] dstore;
        logic [1:0]  rs;
        logic [31:0] rload;
        logic        e_ihit;
        logic        e_dhit;
        logic        e_ren;
        logic        e_wen;
        logic [31:0] e_addr;
        logic [31:0] e_store;
        logic [31:0] e_iload;
        logic [31:0] e_dload;
    } vec_t;

    vec_t vt [15];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                         input logic [31:0] da, input logic [31:0] ds,
                         input logic [1:0] rs, input logic [31:0] rl);
        iREN = ir; iaddr = ia; dREN = dr; dWEN = dw;
        daddr = da; dstore = ds; ramstate = rs; ramload = rl;
    endtask

    task automatic reset_pulse();
        @(negedge CLK);
        nRST = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0, '0, '0, 2'd0, '0);
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    initial begin
        nRST = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0, '0, '0, 2'd0, '0);

        //           iren  iaddr        dren  dwen  daddr         dstore        rs    rload         ihit  dhit  ren   wen   addr          store         iload         dload
        vt[0]  = '{1'b1, 32'h40,      1'b0, 1'b0, 32'h0,        32'h0,        2'd0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        32'h0};
        vt[1]  = '{1'b1, 32'h40,      1'b0, 1'b0, 32'h0,        32'h0,        2'd1, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'h40,       32'h0,        32'h0,        32'h0};
        vt[2]  = '{1'b1, 32'h40,      1'b0, 1'b0, 32'h0,        32'h0,        2'd1, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'h40,       32'h0,        32'h0,        32'h0};
        vt[3]  = '{1'b1, 32'h40,      1'b0, 1'b0, 32'h0,        32'h0,        2'd2, 32'h3C010002, 1'b0, 1'b0, 1'b1, 1'b0, 32'h40,       32'h0,        32'h0,        32'h0};
        vt[4]  = '{1'b0, 32'h0,       1'b0, 1'b0, 32'h0,        32'h0,        2'd0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h3C010002, 32'h0};
        vt[5]  = '{1'b0, 32'h0,       1'b0, 1'b1, 32'h80,       32'hDEADBEEF, 2'd0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h3C010002, 32'h0};
        vt[6]  = '{1'b0, 32'h0,       1'b0, 1'b1, 32'h80,       32'hDEADBEEF, 2'd2, 32'h12345678, 1'b0, 1'b0, 1'b0, 1'b1, 32'h80,       32'hDEADBEEF, 32'h3C010002, 32'h0};
        vt[7]  = '{1'b0, 32'h0,       1'b0, 1'b0, 32'h0,        32'h0,        2'd0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        32'h3C010002, 32'h0};
        vt[8]  = '{1'b1, 32'h4,       1'b1, 1'b0, 32'h100,      32'h0,        2'd0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h3C010002, 32'h0};
        vt[9]  = '{1'b1, 32'h4,       1'b1, 1'b0, 32'h100,      32'h0,        2'd2, 32'hCAFE0001, 1'b0, 1'b0, 1'b1, 1'b0, 32'h100,      32'h0,        32'h3C010002, 32'h0};
        vt[10] = '{1'b1, 32'h4,       1'b0, 1'b0, 32'h0,        32'h0,        2'd0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        32'h3C010002, 32'hCAFE0001};
        vt[11] = '{1'b1, 32'h4,       1'b0, 1'b0, 32'h0,        32'h0,        2'd0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h3C010002, 32'hCAFE0001};
        vt[12] = '{1'b1, 32'h4,       1'b0, 1'b0, 32'h0,        32'h0,        2'd2, 32'h00000AAA, 1'b0, 1'b0, 1'b1, 1'b0, 32'h4,        32'h0,        32'h3C010002, 32'hCAFE0001};
        vt[13] = '{1'b0, 32'h0,       1'b0, 1'b0, 32'h0,        32'h0,        2'd0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h00000AAA, 32'hCAFE0001};
        vt[14] = '{1'b0, 32'h0,       1'b0, 1'b0, 32'h0,        32'h0,        2'd0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h00000AAA, 32'hCAFE0001};

        // reset values
        @(negedge CLK);
        chk("rst_ihit",   {31'b0, ihit},   32'h0);
        chk("rst_dhit",   {31'b0, dhit},   32'h0);
        chk("rst_ramREN", {31'b0, ramREN}, 32'h0);
        chk("rst_ramWEN", {31'b0, ramWEN}, 32'h0);
        chk("rst_error",  {31'b0, error},  32'h0);
        chk("rst_iload",  iload,   32'h0);
        chk("rst_dload",  dload,   32'h0);
        chk("rst_ramaddr", ramaddr, 32'h0);
        chk("rst_ramstore", ramstore, 32'h0);
        nRST = 1'b1;

        // fetch, store, priority: row i = inputs and expected outputs of cycle i
        for (int i = 0; i < 15; i++) begin
            @(negedge CLK);
            chk($sformatf("v%0d_ihit", i),   {31'b0, ihit},   {31'b0, vt[i].e_ihit});
            chk($sformatf("v%0d_dhit", i),   {31'b0, dhit},   {31'b0, vt[i].e_dhit});
            chk($sformatf("v%0d_ramREN", i), {31'b0, ramREN}, {31'b0, vt[i].e_ren});
            chk($sformatf("v%0d_ramWEN", i), {31'b0, ramWEN}, {31'b0, vt[i].e_wen});
            chk($sformatf("v%0d_error", i),  {31'b0, error},  32'h0);
            chk($sformatf("v%0d_iload", i),  iload, vt[i].e_iload);
            chk($sformatf("v%0d_dload", i),  dload, vt[i].e_dload);
            if (vt[i].e_ren || vt[i].e_wen)
                chk($sformatf("v%0d_ramaddr", i), ramaddr, vt[i].e_addr);
            if (vt[i].e_wen)
                chk($sformatf("v%0d_ramstore", i), ramstore, vt[i].e_store);
            drive(vt[i].iren, vt[i].iaddr, vt[i].dren, vt[i].dwen,
                  vt[i].daddr, vt[i].dstore, vt[i].rs, vt[i].rload);
        end

        // async reset in the middle of a fetch
        drive(1'b1, 32'h500, 1'b0, 1'b0, '0, '0, 2'd1, '0);
        @(negedge CLK);
        chk("mid_ramREN_before", {31'b0, ramREN}, 32'h1);
        #2 nRST = 1'b0;
        #1;
        chk("mid_ramREN_async", {31'b0, ramREN}, 32'h0);
        chk("mid_ihit",   {31'b0, ihit},  32'h0);
        chk("mid_error",  {31'b0, error}, 32'h0);
        chk("mid_iload",  iload,   32'h0);
        chk("mid_dload",  dload,   32'h0);
        chk("mid_ramaddr", ramaddr, 32'h0);
        iREN = 1'b0;
        @(negedge CLK);
        chk("mid_ihit_held", {31'b0, ihit}, 32'h0);
        nRST = 1'b1;
        drive(1'b1, 32'h600, 1'b0, 1'b0, '0, '0, 2'd2, 32'h77);
        @(negedge CLK);
        chk("post_ramREN",  {31'b0, ramREN}, 32'h1);
        chk("post_ramaddr", ramaddr, 32'h600);
        @(negedge CLK);
        chk("post_ihit",  {31'b0, ihit}, 32'h1);
        chk("post_iload", iload, 32'h77);
        iREN = 1'b0;

        // timeout with RAM stuck BUSY (TIMEOUT=4)
        reset_pulse();
        drive(1'b1, 32'h200, 1'b0, 1'b0, '0, '0, 2'd1, '0);
        for (int c = 1; c <= 6; c++) begin
            @(negedge CLK);
            chk($sformatf("to_c%0d_ramREN", c), {31'b0, ramREN}, (c <= 4) ? 32'h1 : 32'h0);
            chk($sformatf("to_c%0d_error", c),  {31'b0, error},  (c >= 5) ? 32'h1 : 32'h0);
            chk($sformatf("to_c%0d_ihit", c),   {31'b0, ihit},   32'h0);
        end
        drive(1'b1, 32'h200, 1'b1, 1'b1, 32'h300, 32'h1, 2'd2, 32'h5);
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            chk($sformatf("err_hold%0d_error", c),  {31'b0, error},  32'h1);
            chk($sformatf("err_hold%0d_strobe", c), {30'b0, ramREN, ramWEN}, 32'h0);
            chk($sformatf("err_hold%0d_hits", c),   {30'b0, ihit, dhit},     32'h0);
        end
        reset_pulse();
        chk("err_cleared", {31'b0, error}, 32'h0);

        // RAM ERROR during a data read
        drive(1'b0, '0, 1'b1, 1'b0, 32'h300, '0, 2'd0, '0);
        @(negedge CLK);
        chk("re_ramREN",  {31'b0, ramREN}, 32'h1);
        chk("re_ramaddr", ramaddr, 32'h300);
        ramstate = 2'd3;
        @(negedge CLK);
        chk("re_error",  {31'b0, error},  32'h1);
        chk("re_dhit",   {31'b0, dhit},   32'h0);
        chk("re_ramREN_off", {31'b0, ramREN}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Memory-side responder for the pipeline's instruction and data requests. Accepts `iREN` from fetch and `dREN`/`dWEN` from the control path, serialises them onto one single-ported RAM through a `ramstate` handshake, and returns `ihit`/`dhit` pulses with `iload`/`dload` data. Data requests have priority over instruction fetch. A stalled or faulting RAM drives the block into a sticky error state.

## Interface
- `TIMEOUT`, 16, number of access-state cycles without `ACCESS` before the block declares an error (≥2)
- `CLK`  in  1  clock; all state updates on the rising edge
- `nRST`  in  1  asynchronous, active-low reset
- `iREN`  in  1  instruction read request, level
- `iaddr`  in  32  instruction address
- `dREN`  in  1  data read request (LW), level
- `dWEN`  in  1  data write request (SW), level
- `daddr`  in  32  data address
- `dstore`  in  32  data write value
- `ihit`  out  1  one-cycle pulse: instruction read complete, `iload` valid
- `dhit`  out  1  one-cycle pulse: data read or write complete, `dload` valid for reads
- `iload`  out  32  registered instruction word
- `dload`  out  32  registered data word
- `ramREN`  out  1  RAM read strobe
- `ramWEN`  out  1  RAM write strobe
- `ramaddr`  out  32  RAM address
- `ramstore`  out  32  RAM write data
- `ramload`  in  32  RAM read data, valid when `ramstate`=ACCESS
- `ramstate`  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3
- `error`  out  1  sticky fault flag

## Operation
- States: IDLE, IACC, DACC, RESP, ERR.
- **IDLE**
  - If `dWEN|dREN`: latch `daddr`, `dstore` and the request type, then go to DACC. If `dWEN` and `dREN` are both high, the request is a write.
  - Else if `iREN`: latch `iaddr`, then go to IACC.
  - Else stay in IDLE.
- **IACC / DACC**
  - Drive `ramaddr` from the latched address.
  - IACC: `ramREN`=1.
  - DACC: `ramREN`=1 for a read; `ramWEN`=1 and `ramstore` = latched data for a write.
  - Inputs are ignored while in these states; the latched copies are used.
- **On `ramstate`=ACCESS in IACC/DACC**
  - Capture `ramload` into `iload` (IACC) or into `dload` (DACC read). `dload` is unchanged on a write.
  - Go to RESP.
- **On `ramstate`=ERROR, or on TIMEOUT consecutive access cycles without ACCESS**
  - Go to ERR.
  - Both FREE and BUSY count toward the timeout.
- **RESP**
  - Hold for exactly one cycle.
  - Assert `ihit` if the transaction came from IACC, or `dhit` if it came from DACC.
  - RAM strobes are 0.
  - Return to IDLE.
- **ERR**
  - `error`=1; all strobes and hits are 0.
  - Stays in ERR until `nRST`.
- `ramREN`, `ramWEN`, `ihit`, `dhit` and `error` are decoded from state only, so they are glitch-free with respect to the inputs.
- Timeout counter
  - Width is `$clog2(TIMEOUT+1)`.
  - Cleared on entry to IACC/DACC; increments on each access cycle without ACCESS.
  - The transition to ERR happens when the count equals TIMEOUT-1 and `ramstate`≠ACCESS.
  - Must not wrap.

## Timing
- Reset values: state IDLE; `ihit`, `dhit`, `ramREN`, `ramWEN`, `error` = 0; `iload`, `dload`, `ramaddr`, `ramstore`, latched request and counter = 0.
- Reset is asynchronous: asserting `nRST` mid-transaction drops the RAM strobes immediately, with no completion pulse.
- Latency
  - The request is sampled in IDLE at edge 0, and the RAM strobes are driven from cycle 1.
  - If the RAM returns ACCESS in cycle k (k≥1), the hit pulse and valid load appear in cycle k+1.
  - Minimum latency is 2 cycles.
- Requester protocol: the request is held until the hit. A request still high in the hit cycle is re-sampled in the following IDLE cycle, so the requester must drop or change it on the hit edge.
- Back-to-back requests: there is at least one IDLE cycle between transactions.
- Starvation: a pending `iREN` is serviced only in an IDLE cycle with no data request.
- Simultaneous `iREN` and data request in IDLE: the data request is served first. `iREN` is served after `dhit`, provided no new data request is present.

## Test plan
- Instruction fetch:
  - Stimulus: `iREN`=1, `iaddr`=0x40; RAM returns BUSY for 2 cycles then ACCESS with `ramload`=0x3C01_0002.
  - Required: `ramREN`=1 and `ramaddr`=0x40 from cycle 1; `ihit` high for 1 cycle in cycle 4; `iload`=0x3C01_0002.
- Store:
  - Stimulus: `dWEN`=1, `daddr`=0x80, `dstore`=0xDEAD_BEEF; ACCESS in first cycle.
  - Required: `ramWEN`=1, `ramstore`=0xDEAD_BEEF in cycle 1; `dhit` in cycle 2; `dload` unchanged.
- Priority:
  - Stimulus: `iREN` and `dREN` high together (`daddr`=0x100, `iaddr`=0x4).
  - Required: data access to 0x100 completes first, then after one IDLE cycle the fetch of 0x4; exactly one `dhit` and one `ihit`.
- Timeout:
  - Stimulus: TIMEOUT=4, `ramstate` stuck at BUSY.
  - Required: ERR entered after 4 access cycles; `error`=1; no hit; later requests ignored until `nRST`.
- RAM ERROR:
  - Stimulus: `ramstate`=ERROR during DACC.
  - Required: ERR on the next edge; `error`=1.
- Reset mid-transaction:
  - Stimulus: `nRST` pulsed low during IACC.
  - Required: `ramREN` drops asynchronously; all outputs at reset values; no `ihit`; a new request after release completes normally.
